// File: rtl/data_mem_wait_pkg.sv
// Shared types for the wait-state data memory.
// Access sizes, FSM states and byte-enable helper.
package data_mem_wait_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  function automatic logic [3:0] size_mask(
    input mem_size_e s
  );
    unique case (s)
      SIZE_BYTE: size_mask = 4'b0001;
      SIZE_HALF: size_mask = 4'b0011;
      SIZE_WORD: size_mask = 4'b1111;
      default:   size_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_wait_fmt.sv
// Load formatter: picks the addressed lane out
// of a raw word and sign/zero-extends it.
module data_mem_wait_fmt
  import data_mem_wait_pkg::*;
(
  input  mem_size_e   size_i,
  input  logic        signed_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] raw_i,
  output logic [31:0] data_o
);

  logic [31:0] sh;

  // Shift the addressed lane down, then extend.
  always_comb begin
    sh = raw_i >> {off_i, 3'b000};
    unique case (size_i)
      SIZE_BYTE:
        data_o = {{24{signed_i & sh[7]}},
                  sh[7:0]};
      SIZE_HALF:
        data_o = {{16{signed_i & sh[15]}},
                  sh[15:0]};
      SIZE_WORD:
        data_o = raw_i;
      default:
        data_o = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_wait.sv
// Byte-addressed data memory with a fixed
// number of wait states and one outstanding request.
module data_mem_wait
  import data_mem_wait_pkg::*;
#(
  parameter int ADDR_WIDTH_P = 12,
  parameter int LATENCY_P    = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_i,
  input  logic        req_wen_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_signed_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        req_yumi_o,
  output logic        resp_valid_o,
  output logic [31:0] resp_data_o,
  output logic        resp_err_o,
  input  logic        resp_yumi_i
);

  localparam int DEPTH = 2 ** ADDR_WIDTH_P;
  localparam logic [3:0] LAT_M1 =
    4'((LATENCY_P == 0) ? 0 : LATENCY_P - 1);

  logic [7:0]  mem_q [DEPTH];

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] resp_data_q;
  logic        resp_err_q;

  mem_size_e   size;
  logic [1:0]  off;
  logic        accept;
  logic        misal;
  logic        oob;
  logic        err;
  logic [3:0]  be;
  logic [31:0] wdata_sh;
  logic [31:0] raw;
  logic [31:0] ld_data;

  assign size = mem_size_e'(req_size_i);
  assign off  = req_addr_i[1:0];

  assign req_yumi_o = reset & req_valid_i &
                      (state_q == ST_IDLE);
  assign accept = req_yumi_o;

  // Aligned accesses never straddle a word, so
  // checking the untruncated address bits above
  // the array suffices for bounds.
  always_comb begin
    unique case (size)
      SIZE_BYTE: misal = 1'b0;
      SIZE_HALF: misal = off[0];
      SIZE_WORD: misal = (off != 2'b00);
      default:   misal = 1'b1;
    endcase
    oob = (req_addr_i >> ADDR_WIDTH_P) != 32'd0;
    err = misal | oob;
  end

  // Lane enables and lane-aligned store data.
  always_comb begin
    be       = size_mask(size) << off;
    wdata_sh = req_wdata_i << {off, 3'b000};
  end

  // Read the whole aligned word around the address.
  always_comb begin
    raw = '0;
    for (int k = 0; k < 4; k++) begin
      raw[k*8 +: 8] =
        mem_q[{req_addr_i[ADDR_WIDTH_P-1:2],
               k[1:0]}];
    end
  end

  data_mem_wait_fmt u_fmt (
    .size_i   (size),
    .signed_i (req_signed_i),
    .off_i    (off),
    .raw_i    (raw),
    .data_o   (ld_data)
  );

  // Store commits on the accept edge; never reset.
  always_ff @(posedge clk) begin
    if (accept && req_wen_i && !err) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) begin
          mem_q[{req_addr_i[ADDR_WIDTH_P-1:2],
                 k[1:0]}] <= wdata_sh[k*8 +: 8];
        end
      end
    end
  end

  // State and wait counter registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Response is computed at accept and held.
  always_ff @(posedge clk) begin
    if (!reset) begin
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else if (accept) begin
      resp_err_q  <= err;
      resp_data_q <= (err || req_wen_i) ?
                     32'd0 : ld_data;
    end
  end

  // Next-state: IDLE -> (WAIT) -> RESP -> IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (LATENCY_P == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (resp_yumi_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Response outputs are zero outside RESP.
  always_comb begin
    resp_valid_o = (state_q == ST_RESP);
    resp_data_o  = resp_valid_o ?
                   resp_data_q : 32'd0;
    resp_err_o   = resp_valid_o & resp_err_q;
  end

endmodule

// File: tb/tb_data_mem_wait.sv
// Bench for data_mem_wait: two instances (0 and 3
// wait states), a spec-level model and a compare loop.
module tb_data_mem_wait;

  localparam int LAT0 = 0;
  localparam int LAT1 = 3;
  localparam int AW   = 12;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        val   [2];
  logic        wen_s [2];
  logic [1:0]  sz_s  [2];
  logic        sg_s  [2];
  logic [31:0] adr_s [2];
  logic [31:0] wd_s  [2];
  logic        ryumi [2];
  logic        yumi  [2];
  logic        rvld  [2];
  logic [31:0] rdata [2];
  logic        rerr  [2];

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  data_mem_wait #(
    .ADDR_WIDTH_P (AW),
    .LATENCY_P    (LAT0)
  ) dut0 (
    .clk          (clk),
    .reset        (rst_n),
    .req_valid_i  (val[0]),
    .req_wen_i    (wen_s[0]),
    .req_size_i   (sz_s[0]),
    .req_signed_i (sg_s[0]),
    .req_addr_i   (adr_s[0]),
    .req_wdata_i  (wd_s[0]),
    .req_yumi_o   (yumi[0]),
    .resp_valid_o (rvld[0]),
    .resp_data_o  (rdata[0]),
    .resp_err_o   (rerr[0]),
    .resp_yumi_i  (ryumi[0])
  );

  data_mem_wait #(
    .ADDR_WIDTH_P (AW),
    .LATENCY_P    (LAT1)
  ) dut1 (
    .clk          (clk),
    .reset        (rst_n),
    .req_valid_i  (val[1]),
    .req_wen_i    (wen_s[1]),
    .req_size_i   (sz_s[1]),
    .req_signed_i (sg_s[1]),
    .req_addr_i   (adr_s[1]),
    .req_wdata_i  (wd_s[1]),
    .req_yumi_o   (yumi[1]),
    .resp_valid_o (rvld[1]),
    .resp_data_o  (rdata[1]),
    .resp_err_o   (rerr[1]),
    .resp_yumi_i  (ryumi[1])
  );

  function automatic int lat(input int d);
    return (d == 0) ? LAT0 : LAT1;
  endfunction

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    else
      passes++;
  endtask

  // Model state: memory image, busy flag, the
  // cycle the response is due, and its contents.
  logic [7:0]  mm [2][4096];
  bit          mb  [2];
  int          due [2];
  logic [31:0] md  [2];
  logic        me  [2];
  int          cyc   = 0;
  bit          armed = 0;

  always @(posedge clk) begin : model
    int unsigned nb;
    logic        e;
    logic [31:0] v;
    if (!rst_n) begin
      armed = 1;
      mb[0] = 0;
      mb[1] = 0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (mb[d]) begin
          if (cyc >= due[d] && ryumi[d])
            mb[d] = 0;
        end else if (val[d]) begin
          nb = 1 << sz_s[d];
          e = (sz_s[d] == 2'd3) ||
              (adr_s[d] % nb != 0) ||
              (64'(adr_s[d]) + 64'(nb) - 64'd1
               >= 64'd4096);
          v = 32'd0;
          if (!e) begin
            for (int i = 0; i < nb; i++) begin
              if (wen_s[d])
                mm[d][adr_s[d] + i] =
                  wd_s[d][8*i +: 8];
              else
                v[8*i +: 8] = mm[d][adr_s[d] + i];
            end
            if (nb == 1 && sg_s[d])
              v = {{24{v[7]}}, v[7:0]};
            if (nb == 2 && sg_s[d])
              v = {{16{v[15]}}, v[15:0]};
            if (wen_s[d])
              v = 32'd0;
          end
          md[d]  = v;
          me[d]  = e;
          mb[d]  = 1;
          due[d] = cyc + 1 + lat(d);
        end
      end
    end
    cyc++;
  end

  // Every cycle after reset, compare all outputs.
  always @(negedge clk) begin : compare
    bit ev;
    if (armed) begin
      for (int d = 0; d < 2; d++) begin
        ev = mb[d] && (cyc >= due[d]);
        chk($sformatf("yumi%0d", d), 32'(yumi[d]),
            32'(rst_n && val[d] && !mb[d]));
        chk($sformatf("valid%0d", d),
            32'(rvld[d]), 32'(ev));
        chk($sformatf("data%0d", d), rdata[d],
            ev ? md[d] : 32'd0);
        chk($sformatf("err%0d", d), 32'(rerr[d]),
            32'(ev & me[d]));
      end
    end
  end

  task automatic drive(
    input int          d,
    input logic        wen,
    input logic [1:0]  sz,
    input logic        sg,
    input logic [31:0] a,
    input logic [31:0] wd
  );
    val[d]   = 1'b1;
    wen_s[d] = wen;
    sz_s[d]  = sz;
    sg_s[d]  = sg;
    adr_s[d] = a;
    wd_s[d]  = wd;
  endtask

  task automatic wait_acc(
    input  int    d,
    input  string nm,
    output bit    ok
  );
    ok = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (yumi[d]) begin
        ok = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok)
      chk({nm, "_acc_timeout"}, 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_vld(
    input  int    d,
    input  string nm,
    output bit    ok
  );
    int n;
    ok = 0;
    for (n = 0; n < 40; n++) begin
      @(negedge clk);
      if (rvld[d]) begin
        ok = 1;
        break;
      end
    end
    if (!ok)
      chk({nm, "_resp_timeout"}, 32'd0, 32'd1);
    else
      chk({nm, "_lat"}, 32'(n), 32'(lat(d)));
  endtask

  task automatic consume(input int d);
    @(posedge clk);
    #1;
    ryumi[d] = 1'b1;
    @(posedge clk);
    #1;
    ryumi[d] = 1'b0;
  endtask

  task automatic txn(
    input int          d,
    input logic        wen,
    input logic [1:0]  sz,
    input logic        sg,
    input logic [31:0] a,
    input logic [31:0] wd,
    input int          hold,
    input logic [31:0] xd,
    input logic        xe,
    input string       nm
  );
    bit ok;
    drive(d, wen, sz, sg, a, wd);
    wait_acc(d, nm, ok);
    val[d] = 1'b0;
    if (!ok) return;
    wait_vld(d, nm, ok);
    if (!ok) return;
    chk({nm, "_data"}, rdata[d], xd);
    chk({nm, "_err"}, 32'(rerr[d]), 32'(xe));
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      chk({nm, "_hold_v"}, 32'(rvld[d]), 32'd1);
      chk({nm, "_hold_d"}, rdata[d], xd);
      chk({nm, "_hold_y"}, 32'(yumi[d]), 32'd0);
    end
    consume(d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit hit");
    $fatal(1);
  end

  initial begin
    bit ok;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      val[d]   = 1'b0;
      wen_s[d] = 1'b0;
      sz_s[d]  = 2'd0;
      sg_s[d]  = 1'b0;
      adr_s[d] = 32'd0;
      wd_s[d]  = 32'd0;
      ryumi[d] = 1'b0;
    end
    val[0] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_yumi", 32'(yumi[0]), 32'd0);
    chk("rst_valid", 32'(rvld[0]), 32'd0);
    chk("rst_data", rdata[1], 32'd0);
    chk("rst_err", 32'(rerr[1]), 32'd0);
    @(posedge clk);
    #1;
    val[0] = 1'b0;
    rst_n  = 1'b1;
    @(posedge clk);
    #1;

    txn(0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF,
        0, 32'h0, 0, "st_w10");
    txn(0, 0, 2'd2, 0, 32'h10, 32'h0,
        0, 32'hDEADBEEF, 0, "ld_w10");
    txn(0, 1, 2'd2, 0, 32'h20, 32'h8081F0F1,
        0, 32'h0, 0, "st_w20");
    txn(0, 0, 2'd0, 1, 32'h21, 32'h0,
        0, 32'hFFFFFFF0, 0, "ld_bs21");
    txn(0, 0, 2'd0, 0, 32'h21, 32'h0,
        0, 32'h000000F0, 0, "ld_bu21");
    txn(0, 0, 2'd1, 1, 32'h22, 32'h0,
        0, 32'hFFFF8081, 0, "ld_hs22");
    txn(0, 0, 2'd1, 0, 32'h22, 32'h0,
        0, 32'h00008081, 0, "ld_hu22");
    txn(0, 1, 2'd1, 0, 32'h13, 32'hAAAA,
        0, 32'h0, 1, "st_h13");
    txn(0, 0, 2'd2, 0, 32'h10, 32'h0,
        0, 32'hDEADBEEF, 0, "ld_unch");
    txn(0, 1, 2'd2, 0, 32'h1000, 32'h1,
        0, 32'h0, 1, "st_oob");
    txn(0, 1, 2'd2, 0, 32'hFFE, 32'h1,
        0, 32'h0, 1, "st_ffe");
    txn(0, 1, 2'd3, 0, 32'h10, 32'h1,
        0, 32'h0, 1, "st_rsvd");
    txn(0, 0, 2'd2, 0, 32'h80000010, 32'h0,
        0, 32'h0, 1, "ld_hibit");
    txn(0, 1, 2'd0, 0, 32'h12, 32'h55,
        0, 32'h0, 0, "st_b12");
    txn(0, 0, 2'd2, 0, 32'h10, 32'h0,
        0, 32'hDE55BEEF, 0, "ld_merge");
    txn(0, 1, 2'd2, 0, 32'hFFC, 32'hCAFEF00D,
        0, 32'h0, 0, "st_top");
    txn(0, 0, 2'd1, 0, 32'hFFE, 32'h0,
        0, 32'h0000CAFE, 0, "ld_top");

    txn(1, 1, 2'd2, 0, 32'h40, 32'h0BADF00D,
        0, 32'h0, 0, "st_w40");
    txn(1, 0, 2'd2, 0, 32'h40, 32'h0,
        5, 32'h0BADF00D, 0, "ld_hold");

    drive(1, 0, 2'd2, 0, 32'h40, 32'h0);
    wait_acc(1, "b2b1", ok);
    wait_vld(1, "b2b1", ok);
    chk("b2b1_data", rdata[1], 32'h0BADF00D);
    @(posedge clk);
    #1;
    ryumi[1] = 1'b1;
    @(negedge clk);
    chk("b2b_same", 32'(yumi[1]), 32'd0);
    @(posedge clk);
    #1;
    ryumi[1] = 1'b0;
    @(negedge clk);
    chk("b2b_next", 32'(yumi[1]), 32'd1);
    @(posedge clk);
    #1;
    val[1] = 1'b0;
    wait_vld(1, "b2b2", ok);
    chk("b2b2_data", rdata[1], 32'h0BADF00D);
    consume(1);

    drive(1, 1, 2'd2, 0, 32'h30, 32'h12345678);
    wait_acc(1, "st_rst", ok);
    val[1] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("rst_novld%0d", i),
          32'(rvld[1]), 32'd0);
    end
    @(posedge clk);
    #1;
    txn(1, 0, 2'd2, 0, 32'h30, 32'h0,
        0, 32'h12345678, 0, "ld_after_rst");

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed",
             passes, checks);
    $finish;
  end

endmodule
